// File: rtl/pcie_rx_stream_adapter.sv
`default_nettype none
// ============================================================================
// Module   : pcie_rx_stream_adapter
// Purpose  : Read-side adapter for the PCIe CDC async FIFO (standard mode,
//            1-cycle read latency). Pops 73-bit words and presents them as a
//            valid/ready stream through a 3-entry elastic buffer, splitting
//            each word into data / byte strobe / last and counting frames.
// Ports    : i_clk        - read-domain clock (same as FIFO read clock)
//            i_nrst       - asynchronous active-low reset
//            i_fifo_empty - FIFO empty flag
//            o_fifo_rd_en - FIFO read enable
//            i_fifo_dout  - FIFO data {last, strobe[7:0], data[63:0]}
//            o_valid      - output beat valid
//            i_ready      - sink accepts beat
//            o_data       - beat data
//            o_strob      - beat byte strobe
//            o_last       - last beat of frame
//            o_frame_cnt  - frames delivered (wrapping)
//            o_overflow   - sticky buffer overflow flag
// Revision : 1.0 - initial release
// ============================================================================
module pcie_rx_stream_adapter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_nrst,
    input  logic                 i_fifo_empty,
    output logic                 o_fifo_rd_en,
    input  logic [72:0]          i_fifo_dout,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [63:0]          o_data,
    output logic [7:0]           o_strob,
    output logic                 o_last,
    output logic [CNT_WIDTH-1:0] o_frame_cnt,
    output logic                 o_overflow
);

    localparam logic [1:0] c_PTR_LAST = 2'd2;
    localparam logic [1:0] c_OCC_FULL = 2'd3;
    localparam logic [2:0] c_CREDITS  = 3'd3;

    logic [72:0]          r_buf [0:2];
    logic [1:0]           r_wr_ptr;
    logic [1:0]           r_rd_ptr;
    logic [1:0]           r_occ;
    logic                 r_inflight;
    logic                 r_ena;
    logic                 r_overflow;
    logic [CNT_WIDTH-1:0] r_frame_cnt;

    logic [2:0]           w_pending;
    logic                 w_rd_en;
    logic                 w_pop;
    logic                 w_drop;
    logic                 w_write;
    logic [72:0]          w_head;
    logic [72:0]          w_payload;
    logic [1:0]           w_occ_d;

    function automatic logic [1:0] f_ptr_inc(input logic [1:0] ptr);
        return (ptr == c_PTR_LAST) ? 2'd0 : ptr + 2'd1;
    endfunction

    // Credit check counts the in-flight word so a captured word always has
    // a free slot; only registered state and the empty flag are used.
    assign w_pending = {1'b0, r_occ} + {2'b00, r_inflight};
    assign w_rd_en   = r_ena & ~i_fifo_empty & (w_pending < c_CREDITS);

    assign o_valid = (r_occ != 2'd0);
    assign w_pop   = o_valid & i_ready;

    // With the buffer full, a capture is only legal alongside a pop: the
    // write slot then equals the slot being popped this same edge.
    assign w_drop  = r_inflight & (r_occ == c_OCC_FULL) & ~w_pop;
    assign w_write = r_inflight & ~w_drop;

    always_comb begin
        w_head = r_buf[0];
        case (r_rd_ptr)
            2'd1:    w_head = r_buf[1];
            2'd2:    w_head = r_buf[2];
            default: w_head = r_buf[0];
        endcase
    end

    // Gate the payload so it reads zero whenever nothing is held; buffer
    // contents are not reset.
    assign w_payload = o_valid ? w_head : 73'd0;

    always_comb begin
        w_occ_d = r_occ;
        case ({w_write, w_pop})
            2'b10:   w_occ_d = r_occ + 2'd1;
            2'b01:   w_occ_d = r_occ - 2'd1;
            default: w_occ_d = r_occ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_ena       <= 1'b0;
            r_inflight  <= 1'b0;
            r_wr_ptr    <= 2'd0;
            r_rd_ptr    <= 2'd0;
            r_occ       <= 2'd0;
            r_overflow  <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_ena      <= 1'b1;
            r_inflight <= w_rd_en;
            r_occ      <= w_occ_d;
            if (w_write) begin
                r_wr_ptr <= f_ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_ptr_inc(r_rd_ptr);
                if (w_head[72]) begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage array carries no reset.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < 3; i++) begin
            if (w_write && (r_wr_ptr == 2'(i))) begin
                r_buf[i] <= i_fifo_dout;
            end
        end
    end

    assign o_fifo_rd_en = w_rd_en;
    assign o_data       = w_payload[63:0];
    assign o_strob      = w_payload[71:64];
    assign o_last       = w_payload[72];
    assign o_frame_cnt  = r_frame_cnt;
    assign o_overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_pcie_rx_stream_adapter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_pcie_rx_stream_adapter
// Purpose  : Self-checking bench for pcie_rx_stream_adapter. A queue models
//            the upstream FIFO (1-cycle read latency); every pushed word is
//            also queued as an expected beat and a negedge monitor pops and
//            compares on each handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcie_rx_stream_adapter;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          nrst;
    logic          empty;
    logic          rd_en;
    logic [72:0]   dout;
    logic          valid;
    logic          ready;
    logic [63:0]   data;
    logic [7:0]    strob;
    logic          last;
    logic [CW-1:0] fcnt;
    logic          ovf;

    always #5 clk = ~clk;

    pcie_rx_stream_adapter #(.CNT_WIDTH(CW)) dut (
        .i_clk        (clk),
        .i_nrst       (nrst),
        .i_fifo_empty (empty),
        .o_fifo_rd_en (rd_en),
        .i_fifo_dout  (dout),
        .o_valid      (valid),
        .i_ready      (ready),
        .o_data       (data),
        .o_strob      (strob),
        .o_last       (last),
        .o_frame_cnt  (fcnt),
        .o_overflow   (ovf)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [72:0] fifo_q[$];
    logic [72:0] exp_q[$];
    int          lasts_issued = 0;
    int          mon_frames   = 0;
    int          cyc = 0;
    int          rd_cnt = 0, first_rd = -1, last_rd = -1;
    int          beats = 0, first_beat = -1, last_beat = -1;
    int          rise_cyc = -1;
    bit          pend = 1'b0;
    logic [72:0] pend_word;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [72:0] rand_word(input bit lst);
        return {lst, 8'($urandom()), $urandom(), $urandom()};
    endfunction

    task automatic push(input logic [72:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        if (w[72]) lasts_issued++;
    endtask

    // One clock cycle: FIFO model returns last cycle's popped word, inputs
    // are applied after the edge and the read enable is sampled afterwards.
    task automatic step(input bit rdy, input bit force_empty);
        @(posedge clk);
        #1;
        cyc++;
        dout  = pend ? pend_word : 73'({$urandom(), $urandom(), $urandom()});
        ready = rdy;
        empty = (fifo_q.size() == 0) || force_empty;
        #1;
        pend = 1'b0;
        if (rd_en) begin
            rd_cnt++;
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
            if (empty) begin
                n_tests++;
                n_fail++;
                $display("FAIL rd_en_on_empty: got rd_en=1 expected 0 at cycle %0d", cyc);
            end else begin
                pend_word = fifo_q.pop_front();
                pend      = 1'b1;
            end
        end
    endtask

    // Monitor / scoreboard
    bit          prev_hold  = 1'b0;
    bit          prev_valid = 1'b0;
    logic [72:0] prev_word;

    always @(negedge clk) begin
        logic [72:0] w;
        if (!nrst) begin
            prev_hold  = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", 96'(valid), 96'(1));
                chk("hold_payload", 96'({last, strob, data}), 96'(prev_word));
            end
            if (valid && !prev_valid && rise_cyc < 0) rise_cyc = cyc;
            if (valid && ready) begin
                beats++;
                if (first_beat < 0) first_beat = cyc;
                last_beat = cyc;
                chk("frame_cnt_live", 96'(fcnt), 96'(mon_frames % 16));
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %0h expected none", {last, strob, data});
                end else begin
                    w = exp_q.pop_front();
                    chk("beat_payload", 96'({last, strob, data}), 96'(w));
                    if (w[72]) mon_frames++;
                end
            end
            prev_hold  = valid && !ready;
            prev_word  = {last, strob, data};
            prev_valid = valid;
        end
    end

    initial begin
        int pushed;
        nrst  = 1'b0;
        empty = 1'b1;
        ready = 1'b0;
        dout  = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_valid", 96'(valid), 96'(0));
        chk("rst_rd_en", 96'(rd_en), 96'(0));
        chk("rst_ovf", 96'(ovf), 96'(0));
        chk("rst_fcnt", 96'(fcnt), 96'(0));
        chk("rst_payload", 96'({last, strob, data}), 96'(0));
        @(posedge clk);
        #1 nrst = 1'b1;

        // Single word: one read, beat two cycles later, one frame counted
        push({1'b1, 8'hFF, 64'h0123_4567_89AB_CDEF});
        repeat (8) step(1'b1, 1'b0);
        chk("t1_rd_pulses", 96'(rd_cnt), 96'(1));
        chk("t1_latency", 96'(rise_cyc - first_rd), 96'(2));
        chk("t1_frame_cnt", 96'(fcnt), 96'(1));

        // 16 words, sink always ready: back-to-back reads and beats
        for (int i = 0; i < 16; i++) push(rand_word(i == 15));
        rd_cnt = 0; first_rd = -1; beats = 0; first_beat = -1;
        repeat (24) step(1'b1, 1'b0);
        chk("t2_rd_count", 96'(rd_cnt), 96'(16));
        chk("t2_rd_span", 96'(last_rd - first_rd), 96'(15));
        chk("t2_beats", 96'(beats), 96'(16));
        chk("t2_beat_span", 96'(last_beat - first_beat), 96'(15));

        // 10 words with a 20-cycle stall: only 3 reads while stalled
        for (int i = 0; i < 10; i++) push(rand_word(i == 9));
        rd_cnt = 0; beats = 0;
        repeat (20) step(1'b0, 1'b0);
        chk("t3_stall_reads", 96'(rd_cnt), 96'(3));
        chk("t3_stall_valid", 96'(valid), 96'(1));
        chk("t3_stall_beats", 96'(beats), 96'(0));
        repeat (20) step(1'b1, 1'b0);
        chk("t3_beats", 96'(beats), 96'(10));
        chk("t3_drained", 96'(exp_q.size()), 96'(0));
        chk("t3_ovf", 96'(ovf), 96'(0));

        // Randomized traffic: random sink ready and random empty flag
        pushed = 0;
        for (int c = 0; c < 80000 && !(pushed == 10000 && exp_q.size() == 0); c++) begin
            if (pushed < 10000 && fifo_q.size() < 8 && $urandom_range(0, 3) != 0) begin
                push(rand_word($urandom_range(0, 3) == 0));
                pushed++;
            end
            step(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
        end
        chk("t4_pushed", 96'(pushed), 96'(10000));
        chk("t4_drained", 96'(exp_q.size()), 96'(0));
        chk("t4_ovf", 96'(ovf), 96'(0));
        chk("t4_frame_cnt", 96'(fcnt), 96'(lasts_issued % 16));

        // Reset with two words buffered and one in flight
        for (int i = 0; i < 5; i++) push(rand_word(1'b0));
        repeat (4) step(1'b0, 1'b0);
        chk("t6_pre_valid", 96'(valid), 96'(1));
        chk("t6_pre_rd_en", 96'(rd_en), 96'(0));
        nrst = 1'b0;
        #1;
        chk("t6_rst_valid", 96'(valid), 96'(0));
        chk("t6_rst_rd_en", 96'(rd_en), 96'(0));
        chk("t6_rst_fcnt", 96'(fcnt), 96'(0));
        fifo_q.delete();
        exp_q.delete();
        pend = 1'b0;
        mon_frames = 0;
        lasts_issued = 0;
        repeat (3) step(1'b1, 1'b0);
        @(posedge clk);
        #1 nrst = 1'b1;
        beats = 0;
        repeat (10) step(1'b1, 1'b0);
        chk("t6_no_stale_beats", 96'(beats), 96'(0));
        chk("t6_valid_idle", 96'(valid), 96'(0));

        // Frame counter wrap with 4-bit width: 15, 0, 1
        for (int i = 0; i < 15; i++) push(rand_word(1'b1));
        repeat (25) step(1'b1, 1'b0);
        chk("t5_cnt15", 96'(fcnt), 96'(15));
        push(rand_word(1'b1));
        repeat (6) step(1'b1, 1'b0);
        chk("t5_cnt0", 96'(fcnt), 96'(0));
        push(rand_word(1'b1));
        repeat (6) step(1'b1, 1'b0);
        chk("t5_cnt1", 96'(fcnt), 96'(1));
        chk("t5_drained", 96'(exp_q.size()), 96'(0));
        chk("final_ovf", 96'(ovf), 96'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
